// File: rtl/apb_i2c_fifo_if.sv
// Bus bundle between the bridge front end (master) and an apb_i2c_fifo instance (slave).
// Signal names match the FIFO's original port names.
interface apb_i2c_fifo_if #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
);
  logic              WR_EN;
  logic [DWIDTH-1:0] WDATA;
  logic              RD_EN;
  logic [DWIDTH-1:0] RDATA;
  logic              EMPTY;
  logic              FULL;
  logic [AW:0]       LEVEL;
  logic              OVERFLOW;
  logic              UNDERFLOW;
  logic              CLR_ERR;

  modport master (
    output WR_EN, WDATA, RD_EN, CLR_ERR,
    input  RDATA, EMPTY, FULL, LEVEL, OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  WR_EN, WDATA, RD_EN, CLR_ERR,
    output RDATA, EMPTY, FULL, LEVEL, OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/apb_i2c_fifo.sv
// First-word-fall-through FIFO between the APB front end and the I2C core,
// with registered empty/full/level status and sticky overflow/underflow flags.
module apb_i2c_fifo #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input logic           PCLK,
  input logic           PRESET,
  apb_i2c_fifo_if.slave bus
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;
  logic              r_overflow;
  logic              r_underflow;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_ovf_evt;
  logic w_unf_evt;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LVL_FULL);

  // A push while full is still accepted when a pop frees the head slot in the same cycle.
  assign w_push    = bus.WR_EN && (!w_full || bus.RD_EN);
  assign w_pop     = bus.RD_EN && !w_empty;
  assign w_ovf_evt = bus.WR_EN && w_full && !bus.RD_EN;
  assign w_unf_evt = bus.RD_EN && w_empty;

  // Storage is deliberately left without reset; the pointers define validity.
  always_ff @(posedge PCLK) begin
    if (!PRESET && w_push) begin
      r_mem[r_wr_ptr] <= bus.WDATA;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end

      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase

      // A new error event in the clearing cycle wins over CLR_ERR.
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end else if (bus.CLR_ERR) begin
        r_overflow <= 1'b0;
      end

      if (w_unf_evt) begin
        r_underflow <= 1'b1;
      end else if (bus.CLR_ERR) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign bus.RDATA     = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.EMPTY     = w_empty;
  assign bus.FULL      = w_full;
  assign bus.LEVEL     = r_level;
  assign bus.OVERFLOW  = r_overflow;
  assign bus.UNDERFLOW = r_underflow;

endmodule

// File: doc/apb_i2c_fifo.md
# apb_i2c_fifo

Synchronous first-word-fall-through FIFO placed between the APB front end and the I2C core of the APB-to-I2C bridge. Two instances are used. The TX instance takes writes from the APB side and is drained by the I2C core. The RX instance takes bytes from the I2C core and is drained by APB reads. It provides the empty and full status that drives the bridge's INT_TX/INT_RX interrupts, plus sticky overflow and underflow flags that feed the bridge's error path.

## Interface
Parameters:
- DWIDTH, 32: data width in bits.
- DEPTH, 8: number of entries. Must be a power of two and at least 2.
- AW, $clog2(DEPTH): pointer width. Derived; do not override.

Ports:
- PCLK  input  1  clock; all logic is on the rising edge.
- PRESET  input  1  reset, synchronous and active-high.
- WR_EN  input  1  push request, sampled at the PCLK edge.
- WDATA  input  DWIDTH  push data.
- RD_EN  input  1  pop request, sampled at the PCLK edge.
- RDATA  output  DWIDTH  head entry (FWFT); 0 while EMPTY.
- EMPTY  output  1  FIFO holds no entries.
- FULL  output  1  FIFO holds DEPTH entries.
- LEVEL  output  AW+1  current entry count, range 0..DEPTH.
- OVERFLOW  output  1  sticky: a push was dropped.
- UNDERFLOW  output  1  sticky: a pop was ignored.
- CLR_ERR  input  1  clears OVERFLOW and UNDERFLOW.

## Operation
- Storage: DEPTH x DWIDTH register array. The array is not reset.
- Pointers: wr_ptr and rd_ptr are AW bits wide and wrap modulo DEPTH. LEVEL is held as a separate (AW+1)-bit counter.
- EMPTY is (LEVEL == 0). FULL is (LEVEL == DEPTH). Both are decoded from the registered LEVEL.
- RDATA = EMPTY ? 0 : mem[rd_ptr]. It is combinational from registered state, so the APB side can sample it in the same cycle RD_EN is high.
- Push accepted when WR_EN and (!FULL or RD_EN). On accept: mem[wr_ptr] <= WDATA, wr_ptr+1.
- Pop accepted when RD_EN and !EMPTY. On accept: rd_ptr+1.
- LEVEL: +1 on push only, -1 on pop only, unchanged when both or neither are accepted.
- Simultaneous push and pop when FULL: both are accepted, LEVEL stays DEPTH, and no overflow is flagged.
- Simultaneous push and pop when EMPTY: the push is accepted and the pop is ignored (no bypass). UNDERFLOW is set and LEVEL becomes 1.
- Push when FULL without RD_EN: WDATA is dropped, state is unchanged, and OVERFLOW is set.
- Pop when EMPTY: state is unchanged and UNDERFLOW is set.
- CLR_ERR clears both sticky flags. If a new error occurs in the same cycle, the set wins.

## Timing
- Reset (PRESET high at an edge): wr_ptr=0, rd_ptr=0, LEVEL=0, EMPTY=1, FULL=0, RDATA=0, OVERFLOW=0, UNDERFLOW=0.
- Reset takes priority over WR_EN, RD_EN and CLR_ERR in the same cycle.
- Reset mid-operation discards all stored entries.
- Push latency is 1 cycle. After the accepting edge, EMPTY falls, LEVEL updates, and RDATA shows the new head if the FIFO was empty.
- Pop: RDATA is valid before the edge at which RD_EN is sampled. After that edge, RDATA shows the next entry, or 0 if the FIFO is now empty.
- One push and one pop per cycle at most. Holding WR_EN or RD_EN high for N cycles performs N operations.
- All status outputs (FULL, EMPTY, LEVEL, OVERFLOW, UNDERFLOW) are registered or decoded from registered state. There is no combinational path from WR_EN or RD_EN to any status output.
- Only RDATA depends combinationally on the array, and only through rd_ptr.

## Test plan
1. Reset: assert PRESET for 2 cycles with WR_EN=1 -> EMPTY=1, FULL=0, LEVEL=0, RDATA=0, both flags 0, and no entry stored.
2. Fill and drain (DEPTH=8):
   - Push 0x11..0x88 on 8 consecutive cycles -> FULL=1, LEVEL=8.
   - Pop 8 cycles -> RDATA sequence 0x11..0x88, then EMPTY=1.
3. Overflow:
   - When full, push 0x99 -> OVERFLOW=1, LEVEL=8, 0x99 never read.
   - Pulse CLR_ERR -> OVERFLOW=0.
4. Underflow and EMPTY corner:
   - Pop when empty -> UNDERFLOW=1, LEVEL=0.
   - Push and pop together when empty with 0xAB -> LEVEL=1, RDATA=0xAB, UNDERFLOW=1.
5. Full corner and wrap-around:
   - Push and pop together when full -> LEVEL stays 8, OVERFLOW=0.
   - 20 interleaved push/pop cycles at LEVEL=3 -> data order preserved across pointer wrap.
6. Reset mid-operation: at LEVEL=5, assert PRESET with CLR_ERR=0 and OVERFLOW=1 -> LEVEL=0, EMPTY=1, OVERFLOW=0; the next push of 0x5A reads back as 0x5A.
